// File: rtl/image_pad_stream.sv
// image_pad_stream
//   Border-padding stage for the streaming image pipeline. Consumes an
//   IMG_WIDTH x IMG_HEIGHT raster from a first-word-fall-through FIFO and pushes
//   an (IMG_WIDTH+2*PAD) x (IMG_HEIGHT+2*PAD) raster into an output FIFO.
//   The border is either a constant (MODE 0, PAD_VALUE) or a replica of the
//   nearest edge pixel (MODE 1). Frames run back-to-back without gaps.
//
// Ports
//   clock       system clock, rising edge
//   reset       synchronous, active-high reset
//   in_rd_en    pop request to the input FIFO
//   in_dout     input FIFO head word (valid while in_empty=0)
//   in_empty    input FIFO empty
//   out_wr_en   push to the output FIFO
//   out_din     pixel pushed when out_wr_en=1
//   out_full    output FIFO full
//   frame_done  pulses with the push of the last padded pixel of a frame
module image_pad_stream #(
    parameter int unsigned        DWIDTH     = 8,
    parameter int unsigned        IMG_WIDTH  = 720,
    parameter int unsigned        IMG_HEIGHT = 540,
    parameter int unsigned        PAD        = 1,
    parameter int unsigned        MODE       = 0,
    parameter logic [DWIDTH-1:0]  PAD_VALUE  = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              in_rd_en,
    input  logic [DWIDTH-1:0] in_dout,
    input  logic              in_empty,
    output logic              out_wr_en,
    output logic [DWIDTH-1:0] out_din,
    input  logic              out_full,
    output logic              frame_done
);

    localparam int unsigned PW = IMG_WIDTH + 2 * PAD;
    localparam int unsigned PH = IMG_HEIGHT + 2 * PAD;
    localparam int unsigned XW = $clog2(PW);
    localparam int unsigned YW = $clog2(PH);

    localparam logic [XW-1:0] XLast     = XW'(PW - 1);
    localparam logic [XW-1:0] XDataLo   = XW'(PAD);
    localparam logic [XW-1:0] XDataHi   = XW'(PAD + IMG_WIDTH);
    localparam logic [XW-1:0] XFillLast = XW'(IMG_WIDTH - 1);
    // In MODE 1 the TOP phase also emits the first image row from the buffer.
    localparam logic [YW-1:0] YTopLast    = YW'(PAD - 1 + MODE);
    localparam logic [YW-1:0] YStreamLast = YW'(IMG_HEIGHT + PAD - 1);
    localparam logic [YW-1:0] YLast       = YW'(PH - 1);

    typedef enum logic [1:0] {StFill, StTop, StStream, StBot} state_e;

    localparam state_e StRestart = (MODE == 1) ? StFill : StTop;

    state_e            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [DWIDTH-1:0] hold_q, hold_d;
    logic [DWIDTH-1:0] fill_px;
    logic              adv;
    logic              x_at_end;
    logic              in_left;
    logic              in_data;

    // Row buffer: only replicate mode needs the previous input row.
    if (MODE == 1) begin : g_rowbuf
        localparam int unsigned BW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
        localparam logic [BW-1:0] BLast = BW'(IMG_WIDTH - 1);

        logic [DWIDTH-1:0] row_mem [IMG_WIDTH];
        logic [BW-1:0]     rd_idx;
        logic [BW-1:0]     wr_idx;

        // clamp(x-PAD, 0, IMG_WIDTH-1)
        always_comb begin
            rd_idx = '0;
            if (x_q < XDataLo) begin
                rd_idx = '0;
            end else if (x_q >= XDataHi) begin
                rd_idx = BLast;
            end else begin
                rd_idx = BW'(x_q - XDataLo);
            end
        end

        always_comb begin
            wr_idx = (state_q == StFill) ? BW'(x_q) : BW'(x_q - XDataLo);
        end

        // Every pop (FILL or STREAM data column) refreshes the buffer.
        always_ff @(posedge clock) begin
            if (in_rd_en) begin
                row_mem[wr_idx] <= in_dout;
            end
        end

        assign fill_px = row_mem[rd_idx];
    end else begin : g_nobuf
        assign fill_px = PAD_VALUE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StRestart;
            x_q     <= '0;
            y_q     <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hold_q  <= hold_d;
        end
    end

    assign x_at_end = (x_q == XLast);
    assign in_left  = (x_q < XDataLo);
    assign in_data  = !in_left && (x_q < XDataHi);

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        hold_d     = hold_q;
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        out_din    = PAD_VALUE;
        frame_done = 1'b0;
        adv        = 1'b0;

        case (state_q)
            StFill: begin
                if (MODE == 1) begin
                    if (!in_empty) begin
                        in_rd_en = 1'b1;
                        if (x_q == XFillLast) begin
                            x_d     = '0;
                            state_d = StTop;
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                    end
                end else begin
                    state_d = StRestart;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            StTop: begin
                out_din = fill_px;
                if (!out_full) begin
                    out_wr_en = 1'b1;
                    adv       = 1'b1;
                    if (x_at_end && y_q == YTopLast) begin
                        state_d = StStream;
                    end
                end
            end
            StStream: begin
                if (in_data) begin
                    out_din = in_dout;
                    if (!out_full && !in_empty) begin
                        out_wr_en = 1'b1;
                        in_rd_en  = 1'b1;
                        hold_d    = in_dout;
                        adv       = 1'b1;
                    end
                end else if (in_left) begin
                    // Replicate mode peeks at the row's first pixel without popping it.
                    out_din = (MODE == 1) ? in_dout : PAD_VALUE;
                    if (!out_full && ((MODE == 0) || !in_empty)) begin
                        out_wr_en = 1'b1;
                        adv       = 1'b1;
                    end
                end else begin
                    out_din = (MODE == 1) ? hold_q : PAD_VALUE;
                    if (!out_full) begin
                        out_wr_en = 1'b1;
                        adv       = 1'b1;
                    end
                end
                if (adv && x_at_end && y_q == YStreamLast) begin
                    state_d = StBot;
                end
            end
            StBot: begin
                out_din = fill_px;
                if (!out_full) begin
                    out_wr_en = 1'b1;
                    adv       = 1'b1;
                    if (x_at_end && y_q == YLast) begin
                        frame_done = 1'b1;
                        state_d    = StRestart;
                    end
                end
            end
            default: begin
                state_d = StRestart;
                x_d     = '0;
                y_d     = '0;
            end
        endcase

        if (adv) begin
            if (x_at_end) begin
                x_d = '0;
                y_d = (y_q == YLast) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end

        if (reset) begin
            in_rd_en   = 1'b0;
            out_wr_en  = 1'b0;
            frame_done = 1'b0;
        end
    end

endmodule

// File: doc/image_pad_stream.md
Name: image_pad_stream

Overview:
- Parametrised border-padding stage for the streaming image pipeline. Sits between the input pixel FIFO and the window/filter stages (e.g. the Sobel line buffer).
- Takes an IMG_WIDTH x IMG_HEIGHT raster of DWIDTH-bit pixels and emits a (IMG_WIDTH+2*PAD) x (IMG_HEIGHT+2*PAD) raster.
- Border fill is constant or edge-replicated.
- Processes frames back-to-back indefinitely.

Parameters:
- DWIDTH, 8, pixel width in bits
- IMG_WIDTH, 720, input pixels per row (>=2)
- IMG_HEIGHT, 540, input rows per frame (>=2)
- PAD, 1, border thickness in pixels on every side (1..8)
- MODE, 0, 0 = constant fill with PAD_VALUE; 1 = replicate nearest edge pixel
- PAD_VALUE, 0, fill value for MODE 0 (DWIDTH bits)

Ports:
- clock  in  1  system clock, all logic rising-edge
- reset  in  1  synchronous, active-high reset
- in_rd_en  out  1  pop request to input FIFO
- in_dout  in  DWIDTH  input FIFO head word; first-word-fall-through, valid while in_empty=0
- in_empty  in  1  input FIFO empty
- out_wr_en  out  1  push to output FIFO
- out_din  out  DWIDTH  pixel pushed when out_wr_en=1
- out_full  in  1  output FIFO full
- frame_done  out  1  one-cycle pulse on the cycle the last padded pixel of a frame is pushed

Behaviour:
- Reset is synchronous and active-high on clock.
- Reset clears state to TOP (MODE 0) / FILL (MODE 1), clears x, y and the hold register.
- in_rd_en, out_wr_en and frame_done are combinational from state/flags and read 0 while reset=1. out_din is don't-care when out_wr_en=0.
- Reset mid-frame abandons the frame. The next input word is treated as pixel (0,0).
- Handshake:
  - out_wr_en=1 only if out_full=0.
  - in_rd_en=1 only if in_empty=0, and in the same cycle as out_wr_en=1, except in FILL.
  - Latency in to out is 0 cycles: in_dout is forwarded combinationally when streaming.
  - No push or pop happens on any stalled cycle; counters hold.
- Counters: x over 0..IMG_WIDTH+2*PAD-1, y over 0..IMG_HEIGHT+2*PAD-1. Widths are $clog2 of the padded extents. x wraps to 0 at the end of a row and increments y.
- Row buffer: IMG_WIDTH x DWIDTH RAM, MODE 1 only (omit logic when MODE=0). It holds the most recently read input row. Each pixel read in FILL or STREAM is written at index x-PAD (FILL: index x).
- States:
  - FILL (MODE 1 only): pop IMG_WIDTH pixels into the row buffer with no output; needs in_empty=0 only. Then go to TOP with x=0.
  - TOP (y<PAD): push fill pixels for all padded columns.
    - MODE 0: PAD_VALUE.
    - MODE 1: buf[clamp(x-PAD,0,IMG_WIDTH-1)].
    - MODE 1 then emits row y=PAD from the buffer with no pops, since row 0 was already consumed.
    - Next state is STREAM at y = PAD + (MODE==1 ? 1 : 0).
  - STREAM (input rows), per row:
    - Left pad x<PAD: push PAD_VALUE (MODE 0), or in_dout without popping (MODE 1, requires in_empty=0).
    - Data x in [PAD, PAD+IMG_WIDTH): pop and push in_dout; also latch it into the hold register.
    - Right pad: push PAD_VALUE or the hold register (last pixel of the row).
    - After y = IMG_HEIGHT+PAD-1 wraps, go to BOT.
  - BOT: PAD rows, same fill rule as TOP. MODE 1 uses the buffer, which now holds the last input row.
    - On the final pixel, frame_done=1.
    - Return to TOP (MODE 0) / FILL (MODE 1) with x=y=0.
- Simultaneous out_full=1 and in_empty=0: stall, no pop.
- A pad cycle needing no input (MODE 0 pad, TOP/BOT) proceeds regardless of in_empty.
- Default/illegal state returns to the reset state next cycle.

Test Plan:
- MODE 0, PAD=1, W=4, H=3, input 1..12, output never full -> 30 pushes.
  - Row 0 is six zeros; row 1 is 0,1,2,3,4,0; row 4 is six zeros.
  - Exactly 12 pops; frame_done on push 30 only.
- MODE 1, PAD=2, W=4, H=3, input 1..12 -> 8x7 output.
  - Rows 0-2 are 1,1,1,2,3,4,4,4.
  - Row 3 is 5,5,5,6,7,8,8,8.
  - Rows 4-6 are 9,9,9,10,11,12,12,12.
  - 4 pops before the first push.
- Backpressure: MODE 0 with out_full toggled every cycle and in_empty random -> output sequence identical to the first test; no push while full; no pop without push.
- Back-to-back frames: two MODE 1 frames streamed continuously -> second frame identical in shape; frame_done pulses exactly twice; no pixel leakage across frames.
- Reset mid-frame: assert reset at output pixel 17 of the first test, then resend 1..12 -> outputs during reset 0; fresh full 30-pixel frame follows.
- PAD_VALUE=8'hFF, MODE 0 -> all border pixels 0xFF, interior unchanged.
